// File: rtl/inst_buffer_ctrl.sv
// rtl/inst_buffer_ctrl.sv - pointer/occupancy/flush controller for the decode-to-dispatch instruction buffer
//
// Purpose: decides which decoded slots are written (at compacted addresses),
// whether a DISPATCH_W group is read from the head, and when to back-pressure
// fetch. Owns head/tail pointers and the occupancy count; the SRAM is external.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   flush_i               discard all buffered instructions
//   stall_i               downstream cannot take a group
//   decodeReady_i         decode packet valid
//   decodedVector_i       per-slot valid bits of the packet
//   writeEnable_o         per-slot SRAM write enable
//   writeAddr_o           slot i address at [i*DEPTH_LOG +: DEPTH_LOG]
//   readAddr_o            read address k = head + k
//   dispatch_o            a group is consumed this cycle
//   instBufferReady_o     RUN and at least one full group buffered
//   stallFetch_o          not enough room for a full packet
//   instCount_o           occupancy
//   state_o               0=RUN, 1=FLUSH, 2=REFILL
//   peakCount_o           (INSTBUF_OCC_STATS_EN) max occupancy since reset/flush
//   fetchStallCycles_o    (INSTBUF_OCC_STATS_EN) saturating fetch-stall cycle count
//
// Optional feature macro: INSTBUF_OCC_STATS_EN

module inst_buffer_ctrl #(
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG  = 5,
  parameter int FETCH_W    = 8,
  parameter int DISPATCH_W = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_i,
  input  logic                            stall_i,
  input  logic                            decodeReady_i,
  input  logic [FETCH_W-1:0]              decodedVector_i,
  output logic [FETCH_W-1:0]              writeEnable_o,
  output logic [FETCH_W*DEPTH_LOG-1:0]    writeAddr_o,
  output logic [DISPATCH_W*DEPTH_LOG-1:0] readAddr_o,
  output logic                            dispatch_o,
  output logic                            instBufferReady_o,
  output logic                            stallFetch_o,
  output logic [DEPTH_LOG:0]              instCount_o,
  output logic [1:0]                      state_o
`ifdef INSTBUF_OCC_STATS_EN
  ,
  output logic [DEPTH_LOG:0]              peakCount_o,
  output logic [31:0]                     fetchStallCycles_o
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG:0]   DW_C     = (DEPTH_LOG+1)'(DISPATCH_W);
  localparam logic [DEPTH_LOG:0]   STALL_TH = (DEPTH_LOG+1)'(DEPTH - FETCH_W);
  localparam logic [DEPTH_LOG-1:0] DW_PTR   = DEPTH_LOG'(DISPATCH_W);

  state_t                 state_q;
  logic [DEPTH_LOG-1:0]   head_q, head_d;
  logic [DEPTH_LOG-1:0]   tail_q, tail_d;
  logic [DEPTH_LOG:0]     count_q, count_d;
  logic [DEPTH_LOG:0]     prefix;
  logic [DEPTH_LOG:0]     nwr;
  logic                   accept;

  assign stallFetch_o      = (count_q > STALL_TH);
  assign instBufferReady_o = (state_q == S_RUN) && (count_q >= DW_C);
  assign instCount_o       = count_q;
  assign state_o           = state_q;

  // Reset is folded into the enables so nothing is written or consumed
  // on the edge that reinitialises the pointers.
  assign accept     = reset & decodeReady_i & ~stallFetch_o & (state_q != S_FLUSH) & ~flush_i;
  assign dispatch_o = reset & ~stall_i & (state_q == S_RUN) & (count_q >= DW_C) & ~flush_i;

  // Each slot lands at tail + number of valid slots below it, so sparse
  // packets pack densely into the ring.
  always_comb begin
    writeEnable_o = '0;
    writeAddr_o   = '0;
    prefix        = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      writeEnable_o[i]                       = accept & decodedVector_i[i];
      writeAddr_o[i*DEPTH_LOG +: DEPTH_LOG]  = tail_q + prefix[DEPTH_LOG-1:0];
      prefix                                 = prefix + {{DEPTH_LOG{1'b0}}, decodedVector_i[i]};
    end
    nwr = accept ? prefix : '0;
  end

  always_comb begin
    readAddr_o = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      readAddr_o[k*DEPTH_LOG +: DEPTH_LOG] = head_q + DEPTH_LOG'(k);
    end
  end

  always_comb begin
    tail_d  = tail_q + nwr[DEPTH_LOG-1:0];
    head_d  = dispatch_o ? (head_q + DW_PTR) : head_q;
    count_d = count_q + nwr - (dispatch_o ? DW_C : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_RUN;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_FLUSH;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      case (state_q)
        S_RUN:    state_q <= S_RUN;
        S_FLUSH:  state_q <= S_REFILL;
        S_REFILL: state_q <= (count_d >= DW_C) ? S_RUN : S_REFILL;
        default:  state_q <= S_RUN;
      endcase
    end
  end

`ifdef INSTBUF_OCC_STATS_EN
  logic [DEPTH_LOG:0] peak_q;
  logic [31:0]        fstall_q;

  assign peakCount_o        = peak_q;
  assign fetchStallCycles_o = fstall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_q   <= '0;
      fstall_q <= '0;
    end else begin
      if (flush_i) begin
        peak_q <= '0;
      end else if (count_d > peak_q) begin
        peak_q <= count_d;
      end
      // Not cleared by flush: this is a long-running performance counter.
      if (stallFetch_o && decodeReady_i && (fstall_q != 32'hFFFF_FFFF)) begin
        fstall_q <= fstall_q + 32'd1;
      end
    end
  end
`endif

endmodule
